pc_branch_predict: RTL and testbench
====================================

// Module: pc_branch_predict
// PURPOSE
//  Parametrised next-PC unit for the fetch stage. Owns the PC register and predicts
//  branches with a 2-bit-counter BHT plus a direct-mapped tagged BTB. Resolves
//  branches/jumps arriving from EX with the same BranchSel/JMPSel/eq/blt encoding
//  as the control unit, and raises flush plus a redirect on mispredict.
// PARAMETERS
//  ADDR_W      32      PC width in bits
//  IDX_W       4       BHT/BTB index bits (2**IDX_W entries each)
//  RESET_PC    '0      PC value loaded on reset
//  CNT_W       16      width of the saturating mispredict counter
// PORTS
//  clk             in   1       clock
//  rst             in   1       async active-high reset
//  stall           in   1       hold PC (a fetch-stage bubble)
//  pc_o            out  ADDR_W  current fetch PC
//  pred_taken_o    out  1       prediction for pc_o; carried down the pipe to EX
//  pred_target_o   out  ADDR_W  predicted target for pc_o; carried to EX
//  ex_valid        in   1       EX holds a resolvable instruction this cycle
//  ex_pc           in   ADDR_W  PC of the EX instruction
//  BranchSel       in   2       00 none, 01 beq, 10 blt, 11 reserved (not taken)
//  eq, blt         in   1       ALU compare flags for the EX instruction
//  JMPSel          in   2       00 none, 01 jump-imm, 10 jump-reg, 11 reserved
//  ex_target       in   ADDR_W  computed branch / jump-imm target
//  ex_reg_target   in   ADDR_W  register target for jump-reg
//  ex_pred_taken   in   1       pred_taken_o that travelled with this instruction
//  ex_pred_target  in   ADDR_W  pred_target_o that travelled with this instruction
//  NextInstrSel_o  out  2       resolved source: 00 seq, 01 jimm, 10 jreg, 11 branch
//  flush_o         out  1       kill IF/ID younger instructions (combinational)
//  mispred_cnt_o   out  CNT_W   saturating count of mispredicts
// BEHAVIOUR
//  Reset (async): pc_o=RESET_PC; all BHT counters=2'b01 (weak not-taken); all BTB
//   valid bits=0; mispred_cnt_o=0. Outputs pred_taken_o=0, flush_o=0 while in reset.
//  Resolution (combinational, gated by ex_valid):
//   BranchSel!=00 -> jump ignored; taken=(01&&eq)||(10&&blt); sel=taken?11:00.
//   BranchSel==00 -> JMPSel 01->sel 01, 10->sel 10, taken=1; else sel 00, taken=0.
//   actual_tgt = (sel==10) ? ex_reg_target : ex_target.
//   mispredict = ex_valid && (taken!=ex_pred_taken || (taken && ex_pred_target!=actual_tgt)).
//   flush_o = mispredict. NextInstrSel_o=00 when !ex_valid.
//  Prediction (combinational on pc_o): idx=pc_o[IDX_W+1:2], tag=pc_o[ADDR_W-1:IDX_W+2].
//   pred_taken_o = BTB hit (valid && tag match) && BHT[idx][1];
//   pred_target_o = hit ? BTB target : pc_o+4.
//  PC update at posedge, priority: mispredict -> (taken?actual_tgt:ex_pc+4), even if
//   stall; else stall -> hold; else pred_taken_o ? pred_target_o : pc_o+4.
//   Redirect latency: 1 cycle (flush_o asserted in cycle N, pc_o valid in N+1).
//   pc_o+4 wraps modulo 2**ADDR_W; bits [1:0] are carried through and never checked.
//  Table update at posedge when ex_valid (independent of stall):
//   conditional branch (01/10): counter +1 if taken, -1 if not, saturating 00..11.
//   taken branch or any jump: BTB[idx(ex_pc)] <= {valid,tag(ex_pc),actual_tgt};
//   jumps also force the counter to 11. Not-taken branches do not touch the BTB.
//   Same-index read/write in one cycle: fetch sees the pre-update value.
//  mispred_cnt_o increments on each mispredict, saturates at all-ones.
//  Reset asserted mid-redirect: reset wins; pending redirect is discarded.
// STRUCTURE
//  pc_pkg: next_sel_t enum (SEL_SEQ, SEL_JIMM, SEL_JREG, SEL_BR), BranchSel/JMPSel
//   localparams, BHT_RESET=2'b01, counter saturate functions.
//  Sub-module pc_pred_table: BHT+BTB arrays, one read port (fetch), one write port
//   (EX), async reset of counters and valid bits.
// TESTING
//  Reset RESET_PC=0x100, no stalls -> pc_o 0x100,0x104,0x108; pred_taken_o=0.
//  beq at 0x10C, eq=1, pred 0 -> flush_o=1, sel=11, next pc_o=ex_target; cnt=1.
//  Same beq taken 2 more times -> 3rd fetch of 0x10C gives pred_taken_o=1, target hit.
//  jreg JMPSel=10, ex_reg_target=0x400, pred_target 0x200 -> flush, pc_o=0x400.
//  Mispredict with stall=1 same cycle -> redirect still applied next cycle.
//  pc_o=0xFFFFFFFC, no branch -> next pc_o=0x00000000; cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/pc_branch_predict_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_branch_predict_pkg
// Desc   : Shared types, encodings and counter helpers for the next-PC unit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pc_branch_predict_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_JIMM = 2'b01,
    SEL_JREG = 2'b10,
    SEL_BR   = 2'b11
  } next_sel_t;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_BEQ   = 2'b01;
  localparam logic [1:0] BR_BLT   = 2'b10;
  localparam logic [1:0] BR_RSVD  = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_IMM  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;
  localparam logic [1:0] JMP_RSVD = 2'b11;

  localparam logic [1:0] BHT_RESET    = 2'b01;
  localparam logic [1:0] BHT_STRONG_T = 2'b11;

  // Counter write-port operations
  localparam logic [1:0] CNT_HOLD = 2'b00;
  localparam logic [1:0] CNT_INC  = 2'b01;
  localparam logic [1:0] CNT_DEC  = 2'b10;
  localparam logic [1:0] CNT_SET  = 2'b11;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_branch_predict_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_branch_predict_if
// Desc   : Fetch-side and EX-side signals of the next-PC unit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface pc_branch_predict_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic [ADDR_W-1:0] pc_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic [1:0]        BranchSel;
  logic              eq;
  logic              blt;
  logic [1:0]        JMPSel;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] ex_reg_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;

  logic [1:0]        NextInstrSel_o;
  logic              flush_o;
  logic [CNT_W-1:0]  mispred_cnt_o;

  modport master (
    output stall, ex_valid, ex_pc, BranchSel, eq, blt, JMPSel,
           ex_target, ex_reg_target, ex_pred_taken, ex_pred_target,
    input  pc_o, pred_taken_o, pred_target_o, NextInstrSel_o, flush_o, mispred_cnt_o
  );

  modport slave (
    input  stall, ex_valid, ex_pc, BranchSel, eq, blt, JMPSel,
           ex_target, ex_reg_target, ex_pred_taken, ex_pred_target,
    output pc_o, pred_taken_o, pred_target_o, NextInstrSel_o, flush_o, mispred_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_branch_predict_pred_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_branch_predict_pred_table
// Desc   : 2-bit BHT plus tagged direct-mapped BTB; one fetch read, one EX write.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pc_branch_predict_pred_table
  import pc_branch_predict_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [IDX_W-1:0]  i_rd_idx,
  output logic [1:0]             o_rd_cnt,
  output logic                   o_rd_valid,
  output logic [TAG_W-1:0]       o_rd_tag,
  output logic [ADDR_W-1:0]      o_rd_tgt,
  input  wire logic [IDX_W-1:0]  i_wr_idx,
  input  wire logic [1:0]        i_cnt_op,
  input  wire logic              i_btb_we,
  input  wire logic [TAG_W-1:0]  i_wr_tag,
  input  wire logic [ADDR_W-1:0] i_wr_tgt
);

  localparam int NENT = 1 << IDX_W;

  logic [1:0]        r_bht   [NENT];
  logic [NENT-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag   [NENT];
  logic [ADDR_W-1:0] r_tgt   [NENT];

  // Reads come straight off the registers, so a same-cycle write is not visible
  assign o_rd_cnt   = r_bht[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_tgt   = r_tgt[i_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        r_bht[i] <= BHT_RESET;
      end
      r_valid <= '0;
    end else begin
      case (i_cnt_op)
        CNT_INC: r_bht[i_wr_idx] <= sat_inc2(r_bht[i_wr_idx]);
        CNT_DEC: r_bht[i_wr_idx] <= sat_dec2(r_bht[i_wr_idx]);
        CNT_SET: r_bht[i_wr_idx] <= BHT_STRONG_T;
        default: ;
      endcase
      if (i_btb_we) begin
        r_valid[i_wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_btb_we) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_tgt[i_wr_idx] <= i_wr_tgt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_branch_predict.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pc_branch_predict
// Desc   : Fetch PC register with BHT/BTB prediction and EX-stage resolution.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pc_branch_predict
  import pc_branch_predict_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IDX_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pc_branch_predict_if.slave bus
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_mis_cnt;

  logic              w_taken;
  next_sel_t         w_sel;
  logic [ADDR_W-1:0] w_actual_tgt;
  logic              w_mispredict;
  logic              w_is_br;
  logic              w_is_jump;
  logic [1:0]        w_cnt_op;
  logic              w_btb_we;

  logic [1:0]        w_rd_cnt;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [ADDR_W-1:0] w_rd_tgt;
  logic              w_hit;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_pc_next;

  // EX-stage resolution: a non-zero BranchSel masks any jump encoding
  always_comb begin
    w_taken   = 1'b0;
    w_sel     = SEL_SEQ;
    w_is_br   = 1'b0;
    w_is_jump = 1'b0;
    if (bus.ex_valid) begin
      if (bus.BranchSel != BR_NONE) begin
        w_is_br = (bus.BranchSel == BR_BEQ) || (bus.BranchSel == BR_BLT);
        w_taken = ((bus.BranchSel == BR_BEQ) && bus.eq) ||
                  ((bus.BranchSel == BR_BLT) && bus.blt);
        w_sel   = w_taken ? SEL_BR : SEL_SEQ;
      end else if (bus.JMPSel == JMP_IMM) begin
        w_taken   = 1'b1;
        w_is_jump = 1'b1;
        w_sel     = SEL_JIMM;
      end else if (bus.JMPSel == JMP_REG) begin
        w_taken   = 1'b1;
        w_is_jump = 1'b1;
        w_sel     = SEL_JREG;
      end
    end
  end

  assign w_actual_tgt = (w_sel == SEL_JREG) ? bus.ex_reg_target : bus.ex_target;
  assign w_mispredict = bus.ex_valid &&
                        ((w_taken != bus.ex_pred_taken) ||
                         (w_taken && (bus.ex_pred_target != w_actual_tgt)));

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_is_br) begin
      w_cnt_op = w_taken ? CNT_INC : CNT_DEC;
    end else if (w_is_jump) begin
      w_cnt_op = CNT_SET;
    end
  end

  assign w_btb_we = w_taken;

  pc_branch_predict_pred_table #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (r_pc[IDX_W+1:2]),
    .o_rd_cnt   (w_rd_cnt),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_tgt   (w_rd_tgt),
    .i_wr_idx   (bus.ex_pc[IDX_W+1:2]),
    .i_cnt_op   (w_cnt_op),
    .i_btb_we   (w_btb_we),
    .i_wr_tag   (bus.ex_pc[ADDR_W-1:IDX_W+2]),
    .i_wr_tgt   (w_actual_tgt)
  );

  assign w_pc_seq      = r_pc + ADDR_W'(4);
  assign w_hit         = w_rd_valid && (w_rd_tag == r_pc[ADDR_W-1:IDX_W+2]);
  assign w_pred_taken  = w_hit && w_rd_cnt[1];
  assign w_pred_target = w_hit ? w_rd_tgt : w_pc_seq;

  // A redirect overrides stall so the younger wrong-path fetch is never kept
  always_comb begin
    w_pc_next = r_pc;
    if (w_mispredict) begin
      w_pc_next = w_taken ? w_actual_tgt : bus.ex_pc + ADDR_W'(4);
    end else if (!bus.stall) begin
      w_pc_next = w_pred_taken ? w_pred_target : w_pc_seq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_mis_cnt <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_o           = r_pc;
  assign bus.pred_taken_o   = w_pred_taken;
  assign bus.pred_target_o  = w_pred_target;
  assign bus.NextInstrSel_o = w_sel;
  assign bus.flush_o        = w_mispredict && !rst;
  assign bus.mispred_cnt_o  = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_predict.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_pc_branch_predict
// Desc   : Directed bench with a behavioural next-PC/predictor model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pc_branch_predict;

  localparam int          ADDR_W   = 32;
  localparam int          IDX_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
  localparam int          CNT_W    = 8;
  localparam int          NENT     = 16;
  localparam int          MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_branch_predict_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_branch_predict #(
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: predictor state as plain integers and full-width tags
  int          m_cnt [NENT];
  bit          m_v   [NENT];
  logic [31:0] m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  logic [31:0] m_pc;
  int          m_mis;

  function automatic void predict(output bit pt, output logic [31:0] ptg);
    int i;
    bit hit;
    i   = int'((m_pc >> 2) % NENT);
    hit = m_v[i] && (m_tag[i] == (m_pc >> 6));
    pt  = hit && (m_cnt[i] >= 2);
    ptg = hit ? m_tgt[i] : m_pc + 32'd4;
  endfunction

  function automatic void resolve(output bit tk, output int sel, output logic [31:0] at,
                                  output bit mis);
    int bs, js;
    bs  = int'(bus.BranchSel);
    js  = int'(bus.JMPSel);
    tk  = 1'b0;
    sel = 0;
    if (bus.ex_valid) begin
      if (bs == 1) tk = bus.eq;
      if (bs == 2) tk = bus.blt;
      if (bs == 1 || bs == 2) sel = tk ? 3 : 0;
      else if (bs == 0 && (js == 1 || js == 2)) begin
        tk  = 1'b1;
        sel = js;
      end
    end
    at  = (sel == 2) ? bus.ex_reg_target : bus.ex_target;
    mis = bus.ex_valid && ((tk != bus.ex_pred_taken) || (tk && bus.ex_pred_target != at));
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    bit          pt, tk, mis;
    logic [31:0] ptg, at;
    int          sel, i;
    if (rst) begin
      m_pc  <= RESET_PC;
      m_mis <= 0;
      for (int k = 0; k < NENT; k++) begin
        m_cnt[k] <= 1;
        m_v[k]   <= 1'b0;
      end
    end else begin
      predict(pt, ptg);
      resolve(tk, sel, at, mis);
      i = int'((bus.ex_pc >> 2) % NENT);
      if (mis) begin
        m_pc <= tk ? at : bus.ex_pc + 32'd4;
        if (m_mis < MAXC) m_mis <= m_mis + 1;
      end else if (!bus.stall) begin
        m_pc <= pt ? ptg : m_pc + 32'd4;
      end
      if (bus.ex_valid) begin
        if (bus.BranchSel == 2'd1 || bus.BranchSel == 2'd2)
          m_cnt[i] <= tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        else if (sel == 1 || sel == 2)
          m_cnt[i] <= 3;
        if (tk) begin
          m_v[i]   <= 1'b1;
          m_tag[i] <= bus.ex_pc >> 6;
          m_tgt[i] <= at;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit          pt, tk, mis;
    logic [31:0] ptg, at;
    int          sel;
    predict(pt, ptg);
    resolve(tk, sel, at, mis);
    chk("pc_o",           bus.pc_o,           m_pc);
    chk("pred_taken_o",   bus.pred_taken_o,   pt);
    chk("pred_target_o",  bus.pred_target_o,  ptg);
    chk("flush_o",        bus.flush_o,        mis && !rst);
    chk("NextInstrSel_o", bus.NextInstrSel_o, sel);
    chk("mispred_cnt_o",  bus.mispred_cnt_o,  m_mis);
  end

  task automatic idle();
    bus.stall          = 1'b0;
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = '0;
    bus.BranchSel      = 2'b00;
    bus.eq             = 1'b0;
    bus.blt            = 1'b0;
    bus.JMPSel         = 2'b00;
    bus.ex_target      = '0;
    bus.ex_reg_target  = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
  endtask

  task automatic ex(input logic [31:0] pc, input logic [1:0] bs, input logic e, input logic l,
                    input logic [1:0] js, input logic [31:0] tgt, input logic [31:0] rtgt,
                    input logic ppt, input logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.BranchSel      = bs;
    bus.eq             = e;
    bus.blt            = l;
    bus.JMPSel         = js;
    bus.ex_target      = tgt;
    bus.ex_reg_target  = rtgt;
    bus.ex_pred_taken  = ppt;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    ex(32'h200, 2'b00, 1'b0, 1'b0, 2'b01, 32'h300, 32'h0, 1'b0, 32'h0);
    #2;
    chk("rst_pc", bus.pc_o, 32'h100);
    chk("rst_flush", bus.flush_o, 1'b0);
    chk("rst_pred", bus.pred_taken_o, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("seq0", bus.pc_o, 32'h100);
    step(); chk("seq1", bus.pc_o, 32'h104);
    step(); chk("seq2", bus.pc_o, 32'h108);
    chk("seq2_pred", bus.pred_taken_o, 1'b0);
    step(); chk("seq3", bus.pc_o, 32'h10C);

    // beq taken, predicted not-taken
    ex(32'h10C, 2'b01, 1'b1, 1'b0, 2'b00, 32'h180, 32'h0, 1'b0, 32'h110);
    #2;
    chk("beq_flush", bus.flush_o, 1'b1);
    chk("beq_sel", bus.NextInstrSel_o, 2'b11);
    step();
    chk("beq_pc", bus.pc_o, 32'h180);
    chk("beq_cnt", bus.mispred_cnt_o, 8'd1);

    // Same beq taken twice more, correctly predicted
    ex(32'h10C, 2'b01, 1'b1, 1'b0, 2'b00, 32'h180, 32'h0, 1'b1, 32'h180);
    #2 chk("beq2_flush", bus.flush_o, 1'b0);
    step(); step();

    // Jump back to 0x10C to fetch it again
    ex(32'h300, 2'b00, 1'b0, 1'b0, 2'b01, 32'h10C, 32'h0, 1'b0, 32'h0);
    step(); idle(); #1;
    chk("refetch_pc", bus.pc_o, 32'h10C);
    chk("refetch_pred", bus.pred_taken_o, 1'b1);
    chk("refetch_tgt", bus.pred_target_o, 32'h180);
    chk("refetch_cnt", bus.mispred_cnt_o, 8'd2);
    step(); chk("follow_pred", bus.pc_o, 32'h180);

    // jump-reg with wrong predicted target
    ex(32'h204, 2'b00, 1'b0, 1'b0, 2'b10, 32'h500, 32'h400, 1'b1, 32'h200);
    #2;
    chk("jreg_flush", bus.flush_o, 1'b1);
    chk("jreg_sel", bus.NextInstrSel_o, 2'b10);
    step(); idle();
    chk("jreg_pc", bus.pc_o, 32'h400);

    // Plain stall holds
    bus.stall = 1'b1;
    step(); chk("stall_hold", bus.pc_o, 32'h400);

    // Mispredict under stall still redirects
    ex(32'h110, 2'b01, 1'b0, 1'b0, 2'b00, 32'h180, 32'h0, 1'b1, 32'h180);
    step(); idle();
    chk("stall_redirect", bus.pc_o, 32'h114);
    chk("stall_cnt", bus.mispred_cnt_o, 8'd4);

    // blt taken, correctly predicted
    ex(32'h104, 2'b10, 1'b0, 1'b1, 2'b00, 32'h150, 32'h0, 1'b1, 32'h150);
    #2;
    chk("blt_flush", bus.flush_o, 1'b0);
    chk("blt_sel", bus.NextInstrSel_o, 2'b11);
    step(); idle();
    chk("blt_pc", bus.pc_o, 32'h118);

    // PC wrap
    ex(32'h500, 2'b00, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
    step(); idle();
    chk("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
    step(); chk("wrap_zero", bus.pc_o, 32'h0);

    // Reserved BranchSel with predicted-taken: mispredict every cycle
    for (int n = 0; n < 300; n++) begin
      ex(32'h800, 2'b11, 1'b1, 1'b1, 2'b01, 32'h900, 32'h0, 1'b1, 32'h900);
      step();
    end
    idle(); #1;
    chk("cnt_sat", bus.mispred_cnt_o, 8'hFF);
    chk("rsvd_pc", bus.pc_o, 32'h804);

    // Reset during a pending redirect
    ex(32'h600, 2'b00, 1'b0, 1'b0, 2'b01, 32'h700, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_pc", bus.pc_o, 32'h100);
    chk("rstmid_flush", bus.flush_o, 1'b0);
    chk("rstmid_cnt", bus.mispred_cnt_o, 8'd0);
    step();
    chk("rstmid_hold", bus.pc_o, 32'h100);
    idle();
    rst = 1'b0;
    step(); chk("rstmid_after", bus.pc_o, 32'h104);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
